// File: rtl/ysyx_22050019_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_lsu
// Multi-cycle RV64 load/store unit between the execute stage and a
// handshaked 64-bit data-memory port. It takes one request at a time. For a
// valid memory request it issues one aligned doubleword bus transaction.
// It then returns either a sign/zero-extended load result or a store
// completion to register writeback. It flags misaligned accesses without
// touching the bus, and it reports bus errors returned by memory.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_*              execute-stage request (valid/ready handshake)
//   mem_req_*         bus request channel (aligned address, lane data, strobes)
//   mem_rsp_*         bus response channel (full doubleword read data, error)
//   out_*             writeback result (valid/ready handshake, fault flags)
// All outputs are registered and read 0 while reset is asserted.
// ---------------------------------------------------------------------------
module ysyx_22050019_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wstrb,
   input  logic        mem_rsp_valid,
   output logic        mem_rsp_ready,
   input  logic [63:0] mem_rsp_rdata,
   input  logic        mem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_wen,
   output logic [4:0]  out_rd,
   output logic [63:0] out_data,
   output logic        out_misalign,
   output logic        out_bus_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   logic [4:0]  rd_r;
   logic [2:0]  off_r;
   logic [1:0]  size_r;
   logic        uns_r;
   logic        load_r;

   logic        is_mem_s;
   logic        misalign_s;

   // Low address bits that must be zero for an access of the given size.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      case (size)
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         2'd3:    align_mask = 3'b111;
         default: align_mask = 3'b111;
      endcase
   endfunction

   // Byte-lane strobes of an aligned access within the doubleword.
   function automatic logic [7:0] lane_strobe(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd0:    lane_strobe = 8'h01 << off;
         2'd1:    lane_strobe = 8'h03 << off;
         2'd2:    lane_strobe = 8'h0F << off;
         2'd3:    lane_strobe = 8'hFF;
         default: lane_strobe = 8'h00;
      endcase
   endfunction

   // Pull the addressed bytes down to bit 0 and extend them to 64 bits.
   function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [63:0] raw;
      raw = rdata >> {off, 3'b000};
      case (size)
         2'd0:    load_extend = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
         2'd1:    load_extend = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         2'd2:    load_extend = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         2'd3:    load_extend = raw;
         default: load_extend = raw;
      endcase
   endfunction

   assign is_mem_s   = in_load | in_store;
   assign misalign_s = (in_addr[2:0] & align_mask(in_size)) != 3'b000;

   // Request/response FSM; every output port is a register written here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         rd_r          <= 5'd0;
         off_r         <= 3'd0;
         size_r        <= 2'd0;
         uns_r         <= 1'b0;
         load_r        <= 1'b0;
         in_ready      <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= 64'd0;
         mem_req_wdata <= 64'd0;
         mem_req_wstrb <= 8'h00;
         mem_rsp_ready <= 1'b0;
         out_valid     <= 1'b0;
         out_wen       <= 1'b0;
         out_rd        <= 5'd0;
         out_data      <= 64'd0;
         out_misalign  <= 1'b0;
         out_bus_err   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  rd_r     <= in_rd;
                  off_r    <= in_addr[2:0];
                  size_r   <= in_size;
                  uns_r    <= in_unsigned;
                  load_r   <= in_load;
                  if (!is_mem_s || misalign_s) begin
                     // No-op or misaligned: answer straight away, bus untouched.
                     state_r      <= DONE;
                     out_valid    <= 1'b1;
                     out_wen      <= 1'b0;
                     out_rd       <= in_rd;
                     out_data     <= 64'd0;
                     out_misalign <= is_mem_s;
                     out_bus_err  <= 1'b0;
                  end else begin
                     state_r       <= REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= ~in_load;
                     mem_req_addr  <= {in_addr[63:3], 3'b000};
                     mem_req_wdata <= in_load ? 64'd0 : (in_wdata << {in_addr[2:0], 3'b000});
                     mem_req_wstrb <= in_load ? 8'h00 : lane_strobe(in_size, in_addr[2:0]);
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state_r       <= RESP;
                  mem_req_valid <= 1'b0;
                  mem_rsp_ready <= 1'b1;
               end
            end
            RESP: begin
               if (mem_rsp_valid) begin
                  state_r       <= DONE;
                  mem_rsp_ready <= 1'b0;
                  out_valid     <= 1'b1;
                  out_rd        <= rd_r;
                  out_misalign  <= 1'b0;
                  if (mem_rsp_err) begin
                     out_bus_err <= 1'b1;
                     out_wen     <= 1'b0;
                     out_data    <= 64'd0;
                  end else if (load_r) begin
                     out_bus_err <= 1'b0;
                     out_wen     <= (rd_r != 5'd0);
                     out_data    <= load_extend(mem_rsp_rdata, off_r, size_r, uns_r);
                  end else begin
                     out_bus_err <= 1'b0;
                     out_wen     <= 1'b0;
                     out_data    <= 64'd0;
                  end
               end
            end
            DONE: begin
               // in_ready rises only after the result has been taken.
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state_r       <= IDLE;
               in_ready      <= 1'b0;
               mem_req_valid <= 1'b0;
               mem_rsp_ready <= 1'b0;
               out_valid     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Self-checking bench for ysyx_22050019_lsu: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_ysyx_22050019_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_load, in_store, in_unsigned;
   logic [63:0] in_addr, in_wdata;
   logic [1:0]  in_size;
   logic [4:0]  in_rd;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
   logic [63:0] mem_rsp_rdata;
   logic        out_valid, out_ready, out_wen, out_misalign, out_bus_err;
   logic [4:0]  out_rd;
   logic [63:0] out_data;

   int vectors = 0;
   int miscompares = 0;

   // observations from the most recent transaction
   logic        obs_timeout, obs_saw_req, obs_req_unstable, obs_out_unstable;
   logic        obs_ready_early, obs_ready_after;
   int          obs_req_first, obs_out_first, obs_hs;
   logic [63:0] obs_addr, obs_wdata, obs_data;
   logic [7:0]  obs_wstrb;
   logic        obs_we, obs_wen, obs_mis, obs_err;
   logic [4:0]  obs_rd;

   always #5 clk = ~clk;

   ysyx_22050019_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_wen(out_wen), .out_rd(out_rd),
      .out_data(out_data), .out_misalign(out_misalign), .out_bus_err(out_bus_err)
   );

   // reference: select nb bytes at byte offset off, extend to 64 bits
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                              input int nb, input logic uns);
      logic [63:0] raw, m, v;
      raw = rdata >> (8 * off);
      if (nb == 8) return raw;
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = raw & m;
      if (!uns && v[8 * nb - 1]) v = v | ~m;
      return v;
   endfunction

   // drive one request and play bus + writeback with the given stall counts
   task automatic run_txn(input logic ld, input logic st, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic [63:0] rdata, input logic err,
                          input int req_stall, input int rsp_stall, input int out_stall);
      int rel, n, req_cnt, rsp_cnt, out_cnt;
      logic done;
      obs_timeout = 1'b0; obs_saw_req = 1'b0; obs_req_unstable = 1'b0; obs_out_unstable = 1'b0;
      obs_ready_early = 1'b0; obs_ready_after = 1'b0;
      obs_req_first = -1; obs_out_first = -1; obs_hs = -1;
      req_cnt = 0; rsp_cnt = 0; out_cnt = 0; done = 1'b0;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (in_ready !== 1'b1) begin
         obs_timeout = 1'b1;
         return;
      end
      in_valid = 1'b1; in_load = ld; in_store = st; in_addr = addr; in_wdata = wdata;
      in_size = size; in_unsigned = uns; in_rd = rd;
      @(posedge clk); #1;
      // scramble request inputs so only latched values can be used
      in_valid = 1'b0; in_load = 1'($urandom); in_store = 1'($urandom);
      in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
      in_size = 2'($urandom); in_unsigned = 1'($urandom); in_rd = 5'($urandom);
      rel = 1;
      while (!done && rel < 60) begin
         if (mem_req_valid) begin
            if (!obs_saw_req) begin
               obs_saw_req = 1'b1; obs_req_first = rel;
               obs_addr = mem_req_addr; obs_wdata = mem_req_wdata;
               obs_wstrb = mem_req_wstrb; obs_we = mem_req_we;
            end else if ({mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_we} !==
                         {obs_addr, obs_wdata, obs_wstrb, obs_we}) begin
               obs_req_unstable = 1'b1;
            end
            mem_req_ready = (req_cnt >= req_stall);
            req_cnt++;
         end else begin
            mem_req_ready = 1'($urandom);
         end
         if (mem_rsp_ready) begin
            mem_rsp_valid = (rsp_cnt >= rsp_stall);
            mem_rsp_rdata = mem_rsp_valid ? rdata : {$urandom, $urandom};
            mem_rsp_err   = mem_rsp_valid ? err : 1'($urandom);
            rsp_cnt++;
         end else begin
            // junk responses outside the response phase must be ignored
            mem_rsp_valid = 1'($urandom);
            mem_rsp_rdata = {$urandom, $urandom};
            mem_rsp_err   = 1'($urandom);
         end
         if (out_valid) begin
            if (obs_out_first < 0) begin
               obs_out_first = rel;
               obs_wen = out_wen; obs_rd = out_rd; obs_data = out_data;
               obs_mis = out_misalign; obs_err = out_bus_err;
            end else if ({out_wen, out_rd, out_data, out_misalign, out_bus_err} !==
                         {obs_wen, obs_rd, obs_data, obs_mis, obs_err}) begin
               obs_out_unstable = 1'b1;
            end
            out_ready = (out_cnt >= out_stall);
            if (out_ready) begin
               obs_hs = rel;
               done = 1'b1;
            end
            out_cnt++;
         end else begin
            out_ready = 1'b0;
         end
         if (in_ready) obs_ready_early = 1'b1;
         @(posedge clk); #1;
         rel++;
      end
      if (!done) obs_timeout = 1'b1;
      else obs_ready_after = in_ready;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
           mem_rsp_ready, out_valid, out_wen, out_rd, out_data, out_misalign, out_bus_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got in_ready=%b req_valid=%b out_valid=%b want all zero",
                  in_ready, mem_req_valid, out_valid);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_lw();
      run_txn(1'b1, 1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b0, 5'd10,
              64'hDEADBEEF_12345678, 1'b0, 0, 0, 0);
      vectors++;
      if (obs_data !== 64'hFFFFFFFF_DEADBEEF) begin
         miscompares++; $display("FAIL lw_data got %h want ffffffffdeadbeef", obs_data);
      end
      vectors++;
      if ({obs_wen, obs_rd, obs_we} !== {1'b1, 5'd10, 1'b0}) begin
         miscompares++; $display("FAIL lw_wen_rd got wen=%b rd=%0d we=%b want 1 10 0", obs_wen, obs_rd, obs_we);
      end
      vectors++;
      if (obs_addr !== 64'h8000_0000) begin
         miscompares++; $display("FAIL lw_req_addr got %h want 80000000", obs_addr);
      end
      vectors++;
      if ({obs_req_first, obs_out_first} !== {32'sd1, 32'sd3}) begin
         miscompares++; $display("FAIL lw_latency got req=%0d out=%0d want 1 3", obs_req_first, obs_out_first);
      end
   endtask

   task automatic test_byte();
      run_txn(1'b1, 1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b1, 5'd7,
              64'h11223344_9C556677, 1'b0, 0, 0, 0);
      vectors++;
      if (obs_data !== 64'h0000_0000_0000_009C) begin
         miscompares++; $display("FAIL lbu_data got %h want 9c", obs_data);
      end
      run_txn(1'b1, 1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0, 5'd7,
              64'h11223344_9C556677, 1'b0, 0, 0, 0);
      vectors++;
      if (obs_data !== 64'hFFFFFFFF_FFFFFF9C) begin
         miscompares++; $display("FAIL lb_data got %h want ffffffffffffff9c", obs_data);
      end
   endtask

   task automatic test_sh();
      run_txn(1'b0, 1'b1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 2'd1, 1'b0, 5'd3,
              64'd0, 1'b0, 0, 0, 0);
      vectors++;
      if ({obs_wstrb, obs_wdata, obs_we} !== {8'hC0, 64'hABCD0000_00000000, 1'b1}) begin
         miscompares++;
         $display("FAIL sh_req got strb=%h wdata=%h we=%b want c0 abcd000000000000 1",
                  obs_wstrb, obs_wdata, obs_we);
      end
      vectors++;
      if ({obs_wen, obs_data} !== {1'b0, 64'd0}) begin
         miscompares++; $display("FAIL sh_result got wen=%b data=%h want 0 0", obs_wen, obs_data);
      end
   endtask

   task automatic test_misalign();
      run_txn(1'b1, 1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0, 5'd9,
              64'h1234_5678_9ABC_DEF0, 1'b0, 0, 0, 0);
      vectors++;
      if ({obs_mis, obs_wen, obs_err, obs_saw_req} !== 4'b1000) begin
         miscompares++;
         $display("FAIL misalign_flags got mis=%b wen=%b err=%b req=%b want 1 0 0 0",
                  obs_mis, obs_wen, obs_err, obs_saw_req);
      end
      vectors++;
      if (obs_out_first !== 1) begin
         miscompares++; $display("FAIL misalign_latency got %0d want 1", obs_out_first);
      end
   endtask

   task automatic test_bus_err();
      run_txn(1'b1, 1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0, 5'd5,
              64'h0102_0304_0506_0708, 1'b1, 0, 0, 0);
      vectors++;
      if ({obs_err, obs_wen, obs_data} !== {1'b1, 1'b0, 64'd0}) begin
         miscompares++;
         $display("FAIL ld_bus_err got err=%b wen=%b data=%h want 1 0 0", obs_err, obs_wen, obs_data);
      end
      run_txn(1'b1, 1'b0, 64'h8000_0018, 64'd0, 2'd3, 1'b0, 5'd0,
              64'h0102_0304_0506_0708, 1'b0, 0, 0, 0);
      vectors++;
      if ({obs_err, obs_wen, obs_data} !== {1'b0, 1'b0, 64'h0102_0304_0506_0708}) begin
         miscompares++;
         $display("FAIL ld_rd0 got err=%b wen=%b data=%h want 0 0 0102030405060708",
                  obs_err, obs_wen, obs_data);
      end
   endtask

   task automatic test_backpressure();
      run_txn(1'b1, 1'b0, 64'h8000_0020, 64'd0, 2'd2, 1'b1, 5'd12,
              64'hCAFEF00D_87654321, 1'b0, 3, 0, 2);
      vectors++;
      if ({obs_req_unstable, obs_out_unstable} !== 2'b00) begin
         miscompares++;
         $display("FAIL bp_stable got req_unstable=%b out_unstable=%b want 0 0",
                  obs_req_unstable, obs_out_unstable);
      end
      vectors++;
      if ({obs_ready_early, obs_ready_after} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_in_ready got early=%b after=%b want 0 1", obs_ready_early, obs_ready_after);
      end
      vectors++;
      if (obs_hs !== 8) begin
         miscompares++; $display("FAIL bp_latency got %0d want 8", obs_hs);
      end
      vectors++;
      if (obs_data !== 64'h0000_0000_8765_4321) begin
         miscompares++; $display("FAIL bp_data got %h want 87654321", obs_data);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_addr = 64'h8000_0040;
      in_size = 2'd3; in_unsigned = 1'b0; in_rd = 5'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      n = 0;
      while (mem_rsp_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      mem_req_ready = 1'b0;
      vectors++;
      if (mem_rsp_ready !== 1'b1) begin
         miscompares++; $display("FAIL midrst_reach_resp got %b want 1", mem_rsp_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({mem_rsp_ready, mem_req_valid, out_valid, in_ready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_async got rsp_ready=%b req_valid=%b out_valid=%b want 0 0 0",
                  mem_rsp_ready, mem_req_valid, out_valid);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL midrst_in_ready got %b want 1", in_ready);
      end
      run_txn(1'b1, 1'b0, 64'h8000_0046, 64'd0, 2'd1, 1'b0, 5'd4,
              64'h8001_0000_0000_0000, 1'b0, 0, 0, 0);
      vectors++;
      if ({obs_timeout, obs_wen, obs_data} !== {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8001}) begin
         miscompares++;
         $display("FAIL midrst_fresh_load got to=%b wen=%b data=%h want 0 1 ffffffffffff8001",
                  obs_timeout, obs_wen, obs_data);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic ld, st, uns, err, mis, exp_wen, exp_err;
         logic [1:0] size;
         logic [4:0] rd;
         logic [63:0] addr, wdata, rdata, exp_data;
         logic [15:0] strb;
         int r, nb, off, rs, ps, os, exp_first;
         r = $urandom_range(0, 9);
         ld = (r >= 1 && r <= 5);
         st = (r >= 5);
         size = 2'($urandom);
         nb = 1 << size;
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % nb);
         off = int'(addr % 8);
         wdata = {$urandom, $urandom};
         rdata = {$urandom, $urandom};
         uns = 1'($urandom);
         rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         err = ($urandom_range(0, 7) == 0);
         rs = $urandom_range(0, 3); ps = $urandom_range(0, 3); os = $urandom_range(0, 3);
         mis = (ld || st) && (addr % nb != 0);
         exp_err = (ld || st) && !mis && err;
         exp_wen = ld && !mis && !err && (rd != 5'd0);
         exp_data = (ld && !mis && !err) ? model_load(rdata, off, nb, uns) : 64'd0;
         exp_first = (!(ld || st) || mis) ? 1 : 3 + rs + ps;
         strb = ((16'd1 << nb) - 16'd1) << off;
         run_txn(ld, st, addr, wdata, size, uns, rd, rdata, err, rs, ps, os);
         vectors++;
         if ({obs_timeout, obs_out_first, obs_hs} !== {1'b0, exp_first, exp_first + os}) begin
            miscompares++;
            $display("FAIL rnd%0d_timing got to=%b out=%0d hs=%0d want 0 %0d %0d",
                     i, obs_timeout, obs_out_first, obs_hs, exp_first, exp_first + os);
         end
         vectors++;
         if ({obs_wen, obs_mis, obs_err, obs_rd, obs_data} !== {exp_wen, mis, exp_err, rd, exp_data}) begin
            miscompares++;
            $display("FAIL rnd%0d_result got wen=%b mis=%b err=%b rd=%0d data=%h want %b %b %b %0d %h",
                     i, obs_wen, obs_mis, obs_err, obs_rd, obs_data, exp_wen, mis, exp_err, rd, exp_data);
         end
         vectors++;
         if (obs_saw_req !== ((ld || st) && !mis)) begin
            miscompares++;
            $display("FAIL rnd%0d_bus_used got %b want %b", i, obs_saw_req, (ld || st) && !mis);
         end
         if ((ld || st) && !mis) begin
            vectors++;
            if ({obs_addr, obs_we} !== {addr & ~64'h7, !ld}) begin
               miscompares++;
               $display("FAIL rnd%0d_req_addr got %h we=%b want %h %b", i, obs_addr, obs_we,
                        addr & ~64'h7, !ld);
            end
            if (!ld) begin
               vectors++;
               if ({obs_wstrb, obs_wdata} !== {strb[7:0], wdata << (8 * off)}) begin
                  miscompares++;
                  $display("FAIL rnd%0d_store_lane got strb=%h wdata=%h want %h %h", i,
                           obs_wstrb, obs_wdata, strb[7:0], wdata << (8 * off));
               end
            end
         end
         vectors++;
         if ({obs_req_unstable, obs_out_unstable, obs_ready_early, obs_ready_after} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rnd%0d_handshake got req_unst=%b out_unst=%b early=%b after=%b want 0 0 0 1",
                     i, obs_req_unstable, obs_out_unstable, obs_ready_early, obs_ready_after);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_addr = 64'd0; in_wdata = 64'd0;
      in_size = 2'd0; in_unsigned = 1'b0; in_rd = 5'd0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'd0; mem_rsp_err = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_lw();
      test_byte();
      test_sh();
      test_misalign();
      test_bus_err();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ysyx_22050019_lsu.md
Name: ysyx_22050019_lsu

Overview:
- Multi-cycle load/store unit between the execute stage and a handshaked data-memory port.
- Consumes the execute stage's memory request (address, store data, width, sign mode, destination register).
- Issues one aligned 64-bit bus transaction and returns a load result or store completion to register writeback.
- Detects misaligned accesses and bus errors.

Parameters:
- None. RV64 widths are fixed: address 64, data 64, register index 5.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute-stage request valid
- in_ready  out  1  LSU can accept a request
- in_load  in  1  request is a load; wins if in_store is also set
- in_store  in  1  request is a store
- in_addr  in  64  byte address
- in_wdata  in  64  store data, right-aligned
- in_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double
- in_unsigned  in  1  zero-extend load result (lbu/lhu/lwu)
- in_rd  in  5  load destination register
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_we  out  1  1=write, 0=read
- mem_req_addr  out  64  in_addr with bits [2:0] cleared
- mem_req_wdata  out  64  store data shifted to byte lane
- mem_req_wstrb  out  8  byte strobes; 0 for reads
- mem_rsp_valid  in  1  bus response valid
- mem_rsp_ready  out  1  LSU accepts response
- mem_rsp_rdata  in  64  read data for the full aligned doubleword
- mem_rsp_err  in  1  bus error on this response
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- out_wen  out  1  register write enable
- out_rd  out  5  register index
- out_data  out  64  extended load data
- out_misalign  out  1  misaligned access; no bus transaction issued
- out_bus_err  out  1  bus returned an error

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset enters IDLE.
- During reset all registered outputs are 0. After reset in_ready=1; in_ready is 1 only in IDLE.
- Accept: in_valid&&in_ready latches all in_* fields.
- Routing on accept:
  - Neither load nor store: go to DONE with out_wen=0 and both fault flags 0.
  - Misaligned (in_addr mod (1<<in_size) != 0): go to DONE with out_misalign=1, out_wen=0. Never touches the bus.
  - Otherwise: go to REQ.
- REQ:
  - mem_req_valid=1; addr/we/wdata/wstrb held stable until mem_req_ready.
  - On handshake: go to RESP.
- Strobes: size0 = 8'h01<<off, size1 = 8'h03<<off, size2 = 8'h0F<<off, size3 = 8'hFF, where off=addr[2:0].
- Store data: mem_req_wdata = in_wdata << (8*off).
- RESP:
  - mem_rsp_ready=1. A response is never accepted in the same cycle as the request handshake. Responses outside RESP are ignored (mem_rsp_ready=0).
  - On mem_rsp_valid: latch the result and go to DONE.
- Result rules:
  - Load: raw = rdata >> (8*off); truncate to size; sign-extend unless in_unsigned; size3 passes through. out_wen = (rd!=0).
  - Store: out_wen=0, out_data=0.
  - mem_rsp_err=1: out_bus_err=1, out_wen=0, out_data=0.
- DONE:
  - out_valid=1; all out_* fields held stable until out_ready.
  - On handshake: go to IDLE. in_ready rises the next cycle; no back-to-back accept in the DONE cycle.
- Latency:
  - Best case, request accepted at cycle 0: mem_req_valid at cycle 1, response accepted at cycle 2, out_valid at cycle 3.
  - Misaligned or no-op: out_valid at cycle 1.
- Stalls: each extra cycle of mem_req_ready=0, mem_rsp_valid=0 or out_ready=0 adds exactly one cycle.
- Reset mid-operation:
  - Immediate return to IDLE; mem_req_valid, mem_rsp_ready and out_valid drop asynchronously.
  - A pending bus response is the bus owner's responsibility to discard.
- One outstanding transaction at a time; no buffering beyond the latched request and result.

Test Plan:
- lw, addr=0x80000004, rdata=0xDEADBEEF_12345678, signed -> out_data=0xFFFFFFFF_DEADBEEF, out_wen=1, mem_req_addr=0x80000000, out_valid at cycle 3.
- lbu, then lb, addr=0x80000003, rdata byte3=0x9C -> lbu gives 0x9C; lb gives 0xFFFFFFFF_FFFFFF9C.
- sh, addr=0x80000006, in_wdata=0xABCD -> wstrb=8'hC0, wdata=0xABCD0000_00000000, we=1, out_wen=0.
- lw, addr=0x80000002 -> out_misalign=1 at cycle 1, mem_req_valid never asserted, out_wen=0.
- ld, rd=5, mem_rsp_err=1 -> out_bus_err=1, out_wen=0; second ld with rd=0 -> out_wen=0 with data returned.
- Backpressure: mem_req_ready low 3 cycles and out_ready low 2 cycles -> request and result fields stable throughout, in_ready=0 until the cycle after the out handshake, total latency 8 cycles.
- Reset pulse while in RESP -> mem_rsp_ready drops immediately; after release in_ready=1 and a fresh load completes correctly.
